lc3_mem_master: RTL and testbench



---
 rtl/lc3_mem_pkg.sv | 18 +
 rtl/lc3_mem_arb.sv | 18 +
 rtl/lc3_mem_master.sv | 150 +++++++++++++++
 tb/tb_lc3_mem_master.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types for the LC-3 memory initiator: word width, FSM states and
// client identifiers used by the arbiter and the master.
package lc3_mem_pkg;

  localparam int LC3_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } mem_state_t;

  typedef enum logic {
    CLIENT_FETCH,
    CLIENT_DATA
  } mem_client_t;

endpackage

// File: rtl/lc3_mem_arb.sv
// Fixed-priority arbiter between the instruction-fetch and data clients.
// Purely combinational; the master only samples the grant while idle.
module lc3_mem_arb
  import lc3_mem_pkg::*;
(
  input  logic        f_req,
  input  logic        d_req,
  output mem_client_t grant,
  output logic        grant_valid
);

  // Data side wins whenever both clients are requesting.
  always_comb begin
    grant       = d_req ? CLIENT_DATA : CLIENT_FETCH;
    grant_valid = f_req | d_req;
  end

endmodule

// File: rtl/lc3_mem_master.sv
// LC-3 memory initiator: arbitrates fetch and data requests, runs one
// request/acknowledge transaction at a time, and returns read data or a
// timeout error to the client that was granted.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; arbitration happens here only
// REQ   | mem_req held high with latched address/data, waiting for ack
// DONE  | one-cycle done pulse (with rdata/err) to the granted client
module lc3_mem_master
  import lc3_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     f_req,
  input  logic [ADDRESS_WIDTH-1:0] f_addr,
  output logic                     f_done,
  output logic [LC3_WORD_W-1:0]    f_rdata,
  output logic                     f_err,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDRESS_WIDTH-1:0] d_addr,
  input  logic [LC3_WORD_W-1:0]    d_wdata,
  output logic                     d_done,
  output logic [LC3_WORD_W-1:0]    d_rdata,
  output logic                     d_err,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [LC3_WORD_W-1:0]    mem_wdata,
  input  logic                     mem_ack,
  input  logic [LC3_WORD_W-1:0]    mem_rdata,
  output logic                     busy
);

  // Counter only ever reaches TIMEOUT-1 before the timeout path takes over,
  // so it cannot wrap.
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mem_state_t       state;
  mem_client_t      client;
  mem_client_t      grant;
  logic             grant_valid;
  logic [CNT_W-1:0] wait_cnt;

  lc3_mem_arb u_arb (
    .f_req       (f_req),
    .d_req       (d_req),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Transaction FSM with all client and memory outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      client    <= CLIENT_FETCH;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      f_done    <= 1'b0;
      f_rdata   <= '0;
      f_err     <= 1'b0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            client   <= grant;
            wait_cnt <= '0;
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            state    <= REQ;
            if (grant == CLIENT_DATA) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= f_addr;
              mem_wdata <= '0;
            end
          end
        end

        REQ: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            wait_cnt <= '0;
            state    <= DONE;
            if (client == CLIENT_DATA) begin
              d_done  <= 1'b1;
              d_err   <= 1'b0;
              // Stores never return memory data to the client.
              d_rdata <= mem_we ? '0 : mem_rdata;
            end else begin
              f_done  <= 1'b1;
              f_err   <= 1'b0;
              f_rdata <= mem_rdata;
            end
          end else if (wait_cnt == CNT_LAST) begin
            mem_req  <= 1'b0;
            wait_cnt <= '0;
            state    <= DONE;
            if (client == CLIENT_DATA) begin
              d_done  <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end else begin
              f_done  <= 1'b1;
              f_err   <= 1'b1;
              f_rdata <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end

        DONE: begin
          f_done   <= 1'b0;
          f_rdata  <= '0;
          f_err    <= 1'b0;
          d_done   <= 1'b0;
          d_rdata  <= '0;
          d_err    <= 1'b0;
          wait_cnt <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_master.sv
// Self-checking bench for lc3_mem_master with a small memory responder.
module tb_lc3_mem_master;

  localparam int AW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_done;
  logic [15:0]   f_rdata;
  logic          f_err;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [15:0]   d_wdata = '0;
  logic          d_done;
  logic [15:0]   d_rdata;
  logic          d_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_ack = 1'b0;
  logic [15:0]   mem_rdata = '0;
  logic          busy;

  always #5 clk = ~clk;

  lc3_mem_master #(.ADDRESS_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_done    (f_done),
    .f_rdata   (f_rdata),
    .f_err     (f_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  typedef struct {
    bit          is_data;
    logic [15:0] rdata;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Responder: acks in the REQ cycle with index rsp_delay (-1 = never);
  // read data is mem_addr ^ rsp_key. force_ack injects a stray ack.
  int          rsp_delay = -1;
  logic [15:0] rsp_key = '0;
  bit          force_ack = 1'b0;
  int          req_cycles = 0;

  always @(posedge clk) begin
    #2;
    if (force_ack || (mem_req && rsp_delay >= 0 && req_cycles == rsp_delay)) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_addr ^ rsp_key;
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 16'hDEAD;
    end
    req_cycles = mem_req ? req_cycles + 1 : 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int bound, output int cycles, output bit got);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < bound) begin
      step();
      cycles++;
      got = f_done | d_done;
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{is_data: 1'b0, rdata: 16'hxxxx, err: 1'b1};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({busy, mem_req, mem_we, f_done, d_done, f_err, d_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: busy/req/we/fdone/ddone/ferr/derr=%b, expected 0000000",
               {busy, mem_req, mem_we, f_done, d_done, f_err, d_err});
    end
    checks++;
    if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || f_rdata !== 16'h0 || d_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_buses: addr=%h wdata=%h frd=%h drd=%h, expected all 0000",
               mem_addr, mem_wdata, f_rdata, d_rdata);
    end
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b mem_req=%b, expected 0 0", busy, mem_req);
    end
  endtask

  task automatic test_fetch_read();
    int cyc;
    bit got;
    exp_t e;
    rsp_delay = 0;
    rsp_key   = 16'h1234 ^ 16'h3000;
    f_addr    = 16'h3000;
    f_req     = 1'b1;
    exp_q.push_back('{is_data: 1'b0, rdata: 16'h1234, err: 1'b0});
    step();
    checks++;
    if ({mem_req, mem_we, busy} !== 3'b101 || mem_addr !== 16'h3000) begin
      errors++;
      $display("FAIL fetch_issue: req/we/busy=%b addr=%h, expected 101 addr=3000",
               {mem_req, mem_we, busy}, mem_addr);
    end
    wait_done(20, cyc, got);
    pop_exp(e);
    checks++;
    if (!got || f_done !== !e.is_data || d_done !== e.is_data ||
        f_rdata !== e.rdata || f_err !== e.err) begin
      errors++;
      $display("FAIL fetch_result: fdone=%b ddone=%b rdata=%h err=%b, expected fdone=1 ddone=0 rdata=%h err=%b",
               f_done, d_done, f_rdata, f_err, e.rdata, e.err);
    end
    checks++;
    if (cyc + 1 !== 2) begin
      errors++;
      $display("FAIL fetch_latency: got %0d cycles, expected 2", cyc + 1);
    end
    f_req = 1'b0;
    step();
    checks++;
    if (f_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_pulse_end: f_done=%b busy=%b, expected 0 0", f_done, busy);
    end
  endtask

  task automatic test_store();
    int cyc = 0;
    int req_hi = 0;
    int unstable = 0;
    bit got = 1'b0;
    exp_t e;
    rsp_delay = 3;
    rsp_key   = 16'h5555;
    d_we      = 1'b1;
    d_addr    = 16'h4000;
    d_wdata   = 16'hBEEF;
    d_req     = 1'b1;
    exp_q.push_back('{is_data: 1'b1, rdata: 16'h0000, err: 1'b0});
    while (!got && cyc < 20) begin
      step();
      cyc++;
      if (mem_req) begin
        req_hi++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h4000 || mem_wdata !== 16'hBEEF) unstable++;
      end
      got = f_done | d_done;
    end
    checks++;
    if (unstable !== 0 || req_hi !== 4) begin
      errors++;
      $display("FAIL store_hold: unstable=%0d req_cycles=%0d, expected 0 and 4", unstable, req_hi);
    end
    pop_exp(e);
    checks++;
    if (!got || d_done !== e.is_data || f_done !== !e.is_data ||
        d_rdata !== e.rdata || d_err !== e.err) begin
      errors++;
      $display("FAIL store_result: ddone=%b fdone=%b rdata=%h err=%b, expected ddone=1 fdone=0 rdata=%h err=%b",
               d_done, f_done, d_rdata, d_err, e.rdata, e.err);
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    step();
  endtask

  task automatic test_contention();
    int cyc;
    bit got;
    exp_t e;
    rsp_delay = 1;
    rsp_key   = 16'hA5A5;
    f_addr    = 16'h0100;
    d_addr    = 16'h0200;
    d_we      = 1'b0;
    exp_q.push_back('{is_data: 1'b1, rdata: 16'h0200 ^ 16'hA5A5, err: 1'b0});
    exp_q.push_back('{is_data: 1'b0, rdata: 16'h0100 ^ 16'hA5A5, err: 1'b0});
    f_req = 1'b1;
    d_req = 1'b1;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0200) begin
      errors++;
      $display("FAIL contention_first: mem_req=%b addr=%h, expected 1 addr=0200", mem_req, mem_addr);
    end
    wait_done(20, cyc, got);
    pop_exp(e);
    checks++;
    if (!got || d_done !== e.is_data || f_done !== !e.is_data ||
        d_rdata !== e.rdata || d_err !== e.err) begin
      errors++;
      $display("FAIL contention_data: ddone=%b fdone=%b rdata=%h, expected ddone=1 fdone=0 rdata=%h",
               d_done, f_done, d_rdata, e.rdata);
    end
    d_req = 1'b0;
    step();
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || f_done !== 1'b0) begin
      errors++;
      $display("FAIL contention_gap: mem_req=%b busy=%b f_done=%b, expected 0 0 0", mem_req, busy, f_done);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0100 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL contention_fetch_issue: mem_req=%b addr=%h we=%b, expected 1 0100 0",
               mem_req, mem_addr, mem_we);
    end
    wait_done(20, cyc, got);
    pop_exp(e);
    checks++;
    if (!got || f_done !== !e.is_data || d_done !== e.is_data ||
        f_rdata !== e.rdata || f_err !== e.err) begin
      errors++;
      $display("FAIL contention_fetch: fdone=%b ddone=%b rdata=%h, expected fdone=1 ddone=0 rdata=%h",
               f_done, d_done, f_rdata, e.rdata);
    end
    f_req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2;
    bit got1, got2;
    exp_t e;
    rsp_delay = 0;
    rsp_key   = 16'h0F0F;
    d_we      = 1'b0;
    d_addr    = 16'h0A00;
    d_req     = 1'b1;
    exp_q.push_back('{is_data: 1'b1, rdata: 16'h0A00 ^ 16'h0F0F, err: 1'b0});
    wait_done(20, cyc1, got1);
    pop_exp(e);
    checks++;
    if (!got1 || d_done !== e.is_data || d_rdata !== e.rdata || d_err !== e.err || cyc1 !== 2) begin
      errors++;
      $display("FAIL b2b_first: ddone=%b rdata=%h cycles=%0d, expected 1 %h 2", d_done, d_rdata, cyc1, e.rdata);
    end
    d_addr = 16'h0B00;
    exp_q.push_back('{is_data: 1'b1, rdata: 16'h0B00 ^ 16'h0F0F, err: 1'b0});
    wait_done(20, cyc2, got2);
    pop_exp(e);
    checks++;
    if (!got2 || d_done !== e.is_data || d_rdata !== e.rdata || d_err !== e.err) begin
      errors++;
      $display("FAIL b2b_second: ddone=%b rdata=%h, expected 1 %h", d_done, d_rdata, e.rdata);
    end
    checks++;
    if (cyc2 !== 3) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles between done pulses, expected 3", cyc2);
    end
    d_req = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int cyc = 0;
    int req_hi = 0;
    bit got = 1'b0;
    exp_t e;
    rsp_delay = -1;
    f_addr    = 16'h5000;
    f_req     = 1'b1;
    exp_q.push_back('{is_data: 1'b0, rdata: 16'h0000, err: 1'b1});
    while (!got && cyc < 20) begin
      step();
      cyc++;
      if (mem_req) req_hi++;
      got = f_done | d_done;
    end
    checks++;
    if (req_hi !== TO) begin
      errors++;
      $display("FAIL timeout_req_len: mem_req high %0d cycles, expected %0d", req_hi, TO);
    end
    pop_exp(e);
    checks++;
    if (!got || f_done !== !e.is_data || d_done !== e.is_data ||
        f_rdata !== e.rdata || f_err !== e.err) begin
      errors++;
      $display("FAIL timeout_result: fdone=%b ddone=%b rdata=%h err=%b, expected 1 0 %h %b",
               f_done, d_done, f_rdata, f_err, e.rdata, e.err);
    end
    f_req = 1'b0;
    step();
    step();
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_req, busy, f_done, d_done, f_err, d_err} !== 6'b0 ||
          f_rdata !== 16'h0 || d_rdata !== 16'h0) begin
        errors++;
        $display("FAIL late_ack_%0d: req/busy/fdone/ddone/ferr/derr=%b frd=%h drd=%h, expected all 0",
                 i, {mem_req, busy, f_done, d_done, f_err, d_err}, f_rdata, d_rdata);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit got;
    exp_t e;
    rsp_delay = -1;
    d_we      = 1'b0;
    d_addr    = 16'h6000;
    d_req     = 1'b1;
    step();
    step();
    checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: mem_req=%b busy=%b, expected 1 1", mem_req, busy);
    end
    reset = 1'b1;
    d_req = 1'b0;
    step();
    checks++;
    if ({mem_req, busy, f_done, d_done} !== 4'b0) begin
      errors++;
      $display("FAIL abort_reset: req/busy/fdone/ddone=%b, expected 0000", {mem_req, busy, f_done, d_done});
    end
    reset = 1'b0;
    step();
    checks++;
    if ({mem_req, busy, f_done, d_done} !== 4'b0) begin
      errors++;
      $display("FAIL abort_no_done: req/busy/fdone/ddone=%b, expected 0000", {mem_req, busy, f_done, d_done});
    end
    rsp_delay = 2;
    rsp_key   = 16'h1111;
    f_addr    = 16'h7000;
    f_req     = 1'b1;
    exp_q.push_back('{is_data: 1'b0, rdata: 16'h7000 ^ 16'h1111, err: 1'b0});
    wait_done(20, cyc, got);
    pop_exp(e);
    checks++;
    if (!got || f_done !== !e.is_data || d_done !== e.is_data ||
        f_rdata !== e.rdata || f_err !== e.err || cyc !== 4) begin
      errors++;
      $display("FAIL post_reset_fetch: fdone=%b ddone=%b rdata=%h err=%b cycles=%0d, expected 1 0 %h 0 4",
               f_done, d_done, f_rdata, f_err, cyc, e.rdata);
    end
    f_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_store();
    test_contention();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
